// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and FSM state type for the 1x4 stream demux
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {ST_IDLE, ST_LOCKED} demux_state_t;
endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry registered output slot with load/drain handshake
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // A load wins over a same-cycle drain so back-to-back beats leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - 1-to-4 stream demux with per-packet channel lock
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     busy,
  output logic [SEL_W-1:0]         cur_sel
);

  demux_state_t     state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] tgt;
  logic             accept;
  logic [NUM_CH-1:0] load;

  // in_sel only matters on a packet's first beat; later beats follow the lock.
  assign tgt      = (state == ST_IDLE) ? in_sel : lock_sel;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) load[tgt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_sel <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!in_last) begin
            state    <= ST_LOCKED;
            lock_sel <= in_sel;
          end
        end
        ST_LOCKED: begin
          if (in_last) begin
            state    <= ST_IDLE;
            lock_sel <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          lock_sel <= '0;
        end
      endcase
    end
  end

  assign busy    = (state == ST_LOCKED);
  assign cur_sel = lock_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*DATA_W +: DATA_W]),
      .last      (out_last[i])
    );
  end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb/tb_demux_1x4_stream.sv - directed self-checking bench for demux_1x4_stream
module tb_demux_1x4_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;
  logic [1:0]  cur_sel;

  int checks = 0;
  int errors = 0;

  demux_1x4_stream #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .cur_sel   (cur_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic l);
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
  endtask

  function automatic logic [7:0] ch(input int i);
    return out_data[i*8 +: 8];
  endfunction

  logic [7:0] vec_data [4];

  initial begin
    vec_data[0] = 8'hA0; vec_data[1] = 8'hB1; vec_data[2] = 8'hC2; vec_data[3] = 8'hD3;
    rst = 1'b1;
    out_ready = 4'b1111;
    drive(8'hFF, 2'd2, 1'b0);

    // Reset held with a beat offered: nothing may load
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_cur_sel", {30'd0, cur_sel}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);

    // Single-beat routing to each channel
    for (int i = 0; i < 4; i++) begin
      drive(vec_data[i], i[1:0], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("route%0d_valid", i), {28'd0, out_valid}, 32'd1 << i);
      chk($sformatf("route%0d_data", i), {24'd0, ch(i)}, {24'd0, vec_data[i]});
      chk($sformatf("route%0d_last", i), {31'd0, out_last[i]}, 32'h1);
      @(negedge clk);
    end
    chk("route_drained", {28'd0, out_valid}, 32'h0);

    // Packet lock: later beats ignore in_sel
    drive(8'h11, 2'd2, 1'b0);
    @(negedge clk);
    chk("lock1_valid", {28'd0, out_valid}, 32'h4);
    chk("lock1_data", {24'd0, ch(2)}, 32'h11);
    chk("lock1_busy", {31'd0, busy}, 32'h1);
    chk("lock1_cur_sel", {30'd0, cur_sel}, 32'h2);
    drive(8'h22, 2'd1, 1'b0);
    @(negedge clk);
    chk("lock2_valid", {28'd0, out_valid}, 32'h4);
    chk("lock2_data", {24'd0, ch(2)}, 32'h22);
    chk("lock2_busy", {31'd0, busy}, 32'h1);
    chk("lock2_cur_sel", {30'd0, cur_sel}, 32'h2);
    drive(8'h33, 2'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lock3_valid", {28'd0, out_valid}, 32'h4);
    chk("lock3_data", {24'd0, ch(2)}, 32'h33);
    chk("lock3_last", {31'd0, out_last[2]}, 32'h1);
    chk("lock3_busy", {31'd0, busy}, 32'h0);
    chk("lock3_cur_sel", {30'd0, cur_sel}, 32'h0);
    @(negedge clk);

    // Backpressure on ch3, then drain and reload without a bubble
    out_ready = 4'b0111;
    drive(8'h44, 2'd3, 1'b1);
    @(negedge clk);
    chk("bp_first_valid", {28'd0, out_valid}, 32'h8);
    chk("bp_first_data", {24'd0, ch(3)}, 32'h44);
    drive(8'h55, 2'd3, 1'b1);
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'h0);
    @(negedge clk);
    chk("bp_hold_data", {24'd0, ch(3)}, 32'h44);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'h0);
    out_ready = 4'b1111;
    #1;
    chk("bp_in_ready_high", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_nobubble_valid", {28'd0, out_valid}, 32'h8);
    chk("bp_second_data", {24'd0, ch(3)}, 32'h55);
    @(negedge clk);
    chk("bp_drained", {28'd0, out_valid}, 32'h0);

    // Stalled ch0 must not block a beat for ch1
    out_ready = 4'b0000;
    drive(8'h5A, 2'd0, 1'b1);
    @(negedge clk);
    chk("ind_ch0_full", {28'd0, out_valid}, 32'h1);
    drive(8'h66, 2'd1, 1'b1);
    #1;
    chk("ind_in_ready", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ind_valid", {28'd0, out_valid}, 32'h3);
    chk("ind_ch1_data", {24'd0, ch(1)}, 32'h66);
    chk("ind_ch0_held", {24'd0, ch(0)}, 32'h5A);
    out_ready = 4'b1111;
    @(negedge clk);
    chk("ind_drained", {28'd0, out_valid}, 32'h0);

    // Reset in the middle of a packet
    drive(8'h77, 2'd1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 4'b0000;
    chk("mid_busy", {31'd0, busy}, 32'h1);
    chk("mid_cur_sel", {30'd0, cur_sel}, 32'h1);
    chk("mid_valid", {28'd0, out_valid}, 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    chk("mid_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("mid_rst_cur_sel", {30'd0, cur_sel}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 4'b1111;
    drive(8'h88, 2'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", {28'd0, out_valid}, 32'h1);
    chk("post_rst_data", {24'd0, ch(0)}, 32'h88);
    chk("post_rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
